// File: rtl/pippo_wbseq_pkg.sv
// Shared widths and FSM encoding for the pippo write-back sequencer.
package pippo_wbseq_pkg;

  localparam int OPERAND_WIDTH  = 32;
  localparam int GPR_ADDR_WIDTH = 5;

  typedef enum logic {
    WBSEQ_IDLE = 1'b0,
    WBSEQ_UPD  = 1'b1
  } wbseq_state_e;

endpackage

// File: rtl/pippo_wbseq.sv
// Write-back sequencer: owns the GPR write port, serializes rD + rA(update) writes.
// Optional second forwarding entry enabled by defining PIPPO_WBSEQ_FWD2_EN.
module pippo_wbseq
  import pippo_wbseq_pkg::*;
#(
  parameter int width = OPERAND_WIDTH,
  parameter int aw    = GPR_ADDR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_freeze,
  input  logic             wb_we,
  input  logic [aw-1:0]    wb_addr,
  input  logic [width-1:0] wb_data,
  input  logic             upd_we,
  input  logic [aw-1:0]    upd_addr,
  input  logic [width-1:0] upd_data,
  output logic             gpr_we,
  output logic [aw-1:0]    gpr_addr,
  output logic [width-1:0] gpr_data,
  output logic             wbseq_stall,
  output logic             fwd_valid,
  output logic [aw-1:0]    fwd_addr,
  output logic [width-1:0] fwd_data
`ifdef PIPPO_WBSEQ_FWD2_EN
  ,
  output logic             fwd2_valid,
  output logic [aw-1:0]    fwd2_addr,
  output logic [width-1:0] fwd2_data
`endif
);

  wbseq_state_e     state_q, state_d;
  logic [aw-1:0]    pend_addr_q, pend_addr_d;
  logic [width-1:0] pend_data_q, pend_data_d;
  logic             dual_accept;

  // Equal destinations collapse to a single primary write; no second cycle needed.
  assign dual_accept = wb_we & upd_we & ~wb_freeze & (wb_addr != upd_addr);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= WBSEQ_IDLE;
      pend_addr_q <= '0;
      pend_data_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
    end
  end

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    case (state_q)
      WBSEQ_IDLE: begin
        if (dual_accept) begin
          state_d     = WBSEQ_UPD;
          pend_addr_d = upd_addr;
          pend_data_d = upd_data;
        end
      end
      WBSEQ_UPD: state_d = WBSEQ_IDLE;
      default:   state_d = WBSEQ_IDLE;
    endcase
  end

  always_comb begin
    gpr_we      = 1'b0;
    gpr_addr    = wb_addr;
    gpr_data    = wb_data;
    wbseq_stall = 1'b0;
    case (state_q)
      WBSEQ_IDLE: begin
        gpr_we = (wb_we | upd_we) & ~wb_freeze;
        if (!wb_we && upd_we) begin
          gpr_addr = upd_addr;
          gpr_data = upd_data;
        end
      end
      WBSEQ_UPD: begin
        gpr_we      = 1'b1;
        gpr_addr    = pend_addr_q;
        gpr_data    = pend_data_q;
        wbseq_stall = 1'b1;
      end
      default: ;
    endcase
    // Reset must silence the port at once, not at the next edge.
    if (rst) gpr_we = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_valid <= 1'b0;
      fwd_addr  <= '0;
      fwd_data  <= '0;
    end else if (gpr_we) begin
      fwd_valid <= 1'b1;
      fwd_addr  <= gpr_addr;
      fwd_data  <= gpr_data;
    end
  end

`ifdef PIPPO_WBSEQ_FWD2_EN
  // Entry 2 holds the write before the last one: entry 1 shifts down on each write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd2_valid <= 1'b0;
      fwd2_addr  <= '0;
      fwd2_data  <= '0;
    end else if (gpr_we) begin
      fwd2_valid <= fwd_valid;
      fwd2_addr  <= fwd_addr;
      fwd2_data  <= fwd_data;
    end
  end
`endif

endmodule

// File: tb/tb_pippo_wbseq.sv
// Scoreboard bench for pippo_wbseq: expected GPR writes queued by stimulus, popped by a monitor.
module tb_pippo_wbseq;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_freeze, wb_we, upd_we;
  logic [4:0]  wb_addr, upd_addr;
  logic [31:0] wb_data, upd_data;
  logic        gpr_we, wbseq_stall, fwd_valid;
  logic [4:0]  gpr_addr, fwd_addr;
  logic [31:0] gpr_data, fwd_data;
`ifdef PIPPO_WBSEQ_FWD2_EN
  logic        fwd2_valid;
  logic [4:0]  fwd2_addr;
  logic [31:0] fwd2_data;
`endif

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  always #5 clk = ~clk;

  pippo_wbseq dut (
    .clk        (clk),
    .rst        (rst),
    .wb_freeze  (wb_freeze),
    .wb_we      (wb_we),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .upd_we     (upd_we),
    .upd_addr   (upd_addr),
    .upd_data   (upd_data),
    .gpr_we     (gpr_we),
    .gpr_addr   (gpr_addr),
    .gpr_data   (gpr_data),
    .wbseq_stall(wbseq_stall),
    .fwd_valid  (fwd_valid),
    .fwd_addr   (fwd_addr),
    .fwd_data   (fwd_data)
`ifdef PIPPO_WBSEQ_FWD2_EN
    ,
    .fwd2_valid (fwd2_valid),
    .fwd2_addr  (fwd2_addr),
    .fwd2_data  (fwd2_data)
`endif
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic uwe, input logic [4:0] ua, input logic [31:0] ud,
                       input logic frz);
    wb_we     = we;
    wb_addr   = wa;
    wb_data   = wd;
    upd_we    = uwe;
    upd_addr  = ua;
    upd_data  = ud;
    wb_freeze = frz;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_fwd(input string name, input logic [4:0] a, input logic [31:0] d);
    check({name, "_fwd_valid"}, 32'(fwd_valid), 32'd1);
    check({name, "_fwd_addr"},  32'(fwd_addr),  32'(a));
    check({name, "_fwd_data"},  fwd_data,       d);
  endtask

  // Monitor: every GPR write the DUT issues must match the oldest queued expectation.
  always @(negedge clk) begin
    if (gpr_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_gpr_write", {27'd0, gpr_addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("gpr_addr", 32'(gpr_addr), 32'(w.addr));
        check("gpr_data", gpr_data, w.data);
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle();
    #12;
    // 1: reset state
    check("rst_gpr_we",    32'(gpr_we),      32'd0);
    check("rst_stall",     32'(wbseq_stall), 32'd0);
    check("rst_fwd_valid", 32'(fwd_valid),   32'd0);
    check("rst_fwd_addr",  32'(fwd_addr),    32'd0);
    check("rst_fwd_data",  fwd_data,         32'd0);
`ifdef PIPPO_WBSEQ_FWD2_EN
    check("rst_fwd2_valid", 32'(fwd2_valid), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // 2: single write
    next_cycle();
    drive(1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 1'b0);
    push(5'd3, 32'hDEAD_BEEF);
    @(negedge clk);
    check("s2_gpr_we", 32'(gpr_we), 32'd1);
    check("s2_stall",  32'(wbseq_stall), 32'd0);
    next_cycle();
    idle();
    @(negedge clk);
    check("s2_stall_after", 32'(wbseq_stall), 32'd0);
    check_fwd("s2", 5'd3, 32'hDEAD_BEEF);

    // 3: dual write, distinct addresses
    next_cycle();
    drive(1'b1, 5'd5, 32'h11, 1'b1, 5'd7, 32'h1000, 1'b0);
    push(5'd5, 32'h11);
    push(5'd7, 32'h1000);
    @(negedge clk);
    check("s3_stall_n", 32'(wbseq_stall), 32'd0);
    next_cycle();
    @(negedge clk);
    check("s3_stall_n1", 32'(wbseq_stall), 32'd1);
    check_fwd("s3_n1", 5'd5, 32'h11);
    next_cycle();
    idle();
    @(negedge clk);
    check("s3_stall_n2", 32'(wbseq_stall), 32'd0);
    check_fwd("s3_n2", 5'd7, 32'h1000);
`ifdef PIPPO_WBSEQ_FWD2_EN
    check("s3_fwd2_valid", 32'(fwd2_valid), 32'd1);
    check("s3_fwd2_addr",  32'(fwd2_addr),  32'd5);
    check("s3_fwd2_data",  fwd2_data,       32'h11);
`endif

    // 4: dual write, equal addresses -> primary only
    next_cycle();
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 32'h4444, 1'b0);
    push(5'd4, 32'h44);
    @(negedge clk);
    check("s4_stall", 32'(wbseq_stall), 32'd0);
    next_cycle();
    idle();
    @(negedge clk);
    check("s4_stall_after", 32'(wbseq_stall), 32'd0);
    check_fwd("s4", 5'd4, 32'h44);

    // 5a: freeze blocks a write, forwarding holds
    next_cycle();
    drive(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 1'b1);
    @(negedge clk);
    check("s5_frz_gpr_we", 32'(gpr_we), 32'd0);
    next_cycle();
    idle();
    @(negedge clk);
    check_fwd("s5_frz", 5'd4, 32'h44);

    // 5b: freeze raised while in UPD does not cancel the second write
    next_cycle();
    drive(1'b1, 5'd10, 32'hA0, 1'b1, 5'd11, 32'hB0, 1'b0);
    push(5'd10, 32'hA0);
    push(5'd11, 32'hB0);
    next_cycle();
    wb_freeze = 1'b1;
    @(negedge clk);
    check("s5_upd_stall",  32'(wbseq_stall), 32'd1);
    check("s5_upd_gpr_we", 32'(gpr_we), 32'd1);
    next_cycle();
    idle();
    @(negedge clk);
    check("s5_upd_stall_after", 32'(wbseq_stall), 32'd0);
    check_fwd("s5_upd", 5'd11, 32'hB0);

    // update-only write goes straight through
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hC0, 1'b0);
    push(5'd12, 32'hC0);
    @(negedge clk);
    check("uo_stall", 32'(wbseq_stall), 32'd0);
    next_cycle();
    idle();
    @(negedge clk);
    check_fwd("uo", 5'd12, 32'hC0);

    // 6: reset pulse in UPD drops the pending r7 write immediately
    next_cycle();
    drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd7, 32'h77, 1'b0);
    push(5'd5, 32'h55);
    next_cycle();
    rst = 1'b1;
    #1;
    check("s6_gpr_we",    32'(gpr_we),      32'd0);
    check("s6_stall",     32'(wbseq_stall), 32'd0);
    check("s6_fwd_valid", 32'(fwd_valid),   32'd0);
    check("s6_fwd_addr",  32'(fwd_addr),    32'd0);
    check("s6_fwd_data",  fwd_data,         32'd0);
`ifdef PIPPO_WBSEQ_FWD2_EN
    check("s6_fwd2_valid", 32'(fwd2_valid), 32'd0);
`endif
    idle();
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
    drive(1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 1'b0);
    push(5'd3, 32'hDEAD_BEEF);
    @(negedge clk);
    check("s6_post_gpr_we", 32'(gpr_we), 32'd1);
    check("s6_post_stall",  32'(wbseq_stall), 32'd0);
    next_cycle();
    idle();
    @(negedge clk);
    check_fwd("s6_post", 5'd3, 32'hDEAD_BEEF);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
